register_file: RTL and testbench

General-purpose register file of 16 × 16-bit registers with one synchronous write port and two combinational read ports, plus a dedicated always-on view of register 0. It sits in the datapath between instruction decode, which drives the select lines, and the ALU/writeback stage, which consumes the operands and supplies the write data.

---
 rtl/register_file.sv | 36 +++
 tb/tb_register_file.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// General-purpose register file: DEPTH x WIDTH storage, one synchronous write
// port, two combinational read ports and a dedicated view of register 0.
module register_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] sel_in,
  input  logic [$clog2(DEPTH)-1:0] sel_o1,
  input  logic [$clog2(DEPTH)-1:0] sel_o2,
  input  logic [WIDTH-1:0]         in,
  output logic [WIDTH-1:0]         o0,
  output logic [WIDTH-1:0]         o1,
  output logic [WIDTH-1:0]         o2
);

  logic [WIDTH-1:0] r_regs [DEPTH];

  // Register 0 is ordinary storage; reads never bypass a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '{default: '0};
    end else if (we) begin
      r_regs[sel_in] <= in;
    end
  end

  always_comb begin
    o0 = r_regs[0];
    o1 = r_regs[sel_o1];
    o2 = r_regs[sel_o2];
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  sel_in;
  logic [3:0]  sel_o1;
  logic [3:0]  sel_o2;
  logic [15:0] in;
  logic [15:0] o0;
  logic [15:0] o1;
  logic [15:0] o2;

  register_file #(.WIDTH(16), .DEPTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .sel_in (sel_in),
    .sel_o1 (sel_o1),
    .sel_o2 (sel_o2),
    .in     (in),
    .o0     (o0),
    .o1     (o1),
    .o2     (o2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] s, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; sel_in = s; in = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; sel_in = '0; sel_o1 = '0; sel_o2 = '0; in = '0;

    sel_o1 = 4'd7; sel_o2 = 4'd9;
    #1;
    n_vec++;
    if (o0 !== 16'h0000 || o1 !== 16'h0000 || o2 !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset: o0=%h o1=%h o2=%h", o0, o1, o2);
    end
    @(negedge clk); rst_n = 1'b1;

    wr(4'd0, 16'h1234);
    wr(4'd6, 16'hA5A5);
    wr(4'd15, 16'h5A5A);
    sel_o1 = 4'd6;
    #1;
    n_vec++;
    if (o1 !== 16'hA5A5) begin
      n_miss++;
      $display("FAIL pre_reset_r6: o1=%h required=a5a5", o1);
    end
    n_vec++;
    if (o0 !== 16'h1234) begin
      n_miss++;
      $display("FAIL pre_reset_r0: o0=%h required=1234", o0);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      sel_o1 = 4'(i); sel_o2 = 4'(15 - i);
      #1;
      n_vec++;
      if (o0 !== 16'h0000 || o1 !== 16'h0000 || o2 !== 16'h0000) begin
        n_miss++;
        $display("FAIL async_reset i=%0d: o0=%h o1=%h o2=%h", i, o0, o1, o2);
      end
    end
    @(negedge clk); rst_n = 1'b1;

    wr(4'd0, 16'h0000);
    sel_o1 = 4'd0;
    #1;
    n_vec++;
    if (o1 !== 16'h0000 || o0 !== 16'h0000) begin
      n_miss++;
      $display("FAIL r0_zero: o0=%h o1=%h", o0, o1);
    end
    wr(4'd0, 16'hBEEF);
    #1;
    n_vec++;
    if (o0 !== 16'hBEEF) begin
      n_miss++;
      $display("FAIL r0_beef_o0: o0=%h required=beef", o0);
    end
    n_vec++;
    if (o1 !== 16'hBEEF) begin
      n_miss++;
      $display("FAIL r0_beef_o1: o1=%h required=beef", o1);
    end

    @(negedge clk);
    we = 1'b1; sel_in = 4'd1; in = 16'h0001;
    @(negedge clk);
    sel_o1 = 4'd1;
    #1;
    n_vec++;
    if (o1 !== 16'h0001) begin
      n_miss++;
      $display("FAIL basic_r1: o1=%h required=0001", o1);
    end
    sel_in = 4'd2; in = 16'h0002;
    @(negedge clk);
    we = 1'b0;
    sel_o1 = 4'd2;
    #1;
    n_vec++;
    if (o1 !== 16'h0002) begin
      n_miss++;
      $display("FAIL basic_r2: o1=%h required=0002", o1);
    end
    sel_o1 = 4'd1;
    #1;
    n_vec++;
    if (o1 !== 16'h0001) begin
      n_miss++;
      $display("FAIL comb_reselect_r1: o1=%h required=0001", o1);
    end

    wr(4'd5, 16'h1111);
    @(negedge clk);
    we = 1'b1; sel_in = 4'd5; in = 16'h2222; sel_o1 = 4'd5; sel_o2 = 4'd5;
    #1;
    n_vec++;
    if (o1 !== 16'h1111 || o2 !== 16'h1111) begin
      n_miss++;
      $display("FAIL nobypass_before: o1=%h o2=%h required=1111", o1, o2);
    end
    @(negedge clk);
    we = 1'b0; in = 16'h3333;
    #1;
    n_vec++;
    if (o1 !== 16'h2222 || o2 !== 16'h2222) begin
      n_miss++;
      $display("FAIL nobypass_after: o1=%h o2=%h required=2222", o1, o2);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (o1 !== 16'h2222) begin
      n_miss++;
      $display("FAIL we0_hold_r5: o1=%h required=2222", o1);
    end

    for (int unsigned i = 0; i < 16; i++) wr(4'(i), 16'(i * 16'h1001));
    for (int unsigned i = 0; i < 16; i++) begin
      sel_o1 = 4'(i); sel_o2 = 4'(15 - i);
      #1;
      n_vec++;
      if (o1 !== 16'(i * 16'h1001) || o2 !== 16'((15 - i) * 16'h1001)) begin
        n_miss++;
        $display("FAIL dual i=%0d: o1=%h o2=%h", i, o1, o2);
      end
    end
    n_vec++;
    if (o0 !== 16'h0000) begin
      n_miss++;
      $display("FAIL dual_o0: o0=%h required=0000", o0);
    end

    @(negedge clk);
    we = 1'b1; sel_in = 4'd3; in = 16'hABCD; rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int unsigned i = 0; i < 16; i++) begin
      sel_o1 = 4'(i);
      #1;
      n_vec++;
      if (o1 !== 16'h0000) begin
        n_miss++;
        $display("FAIL reset_write_ignored i=%0d: o1=%h", i, o1);
      end
    end
    we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wr(4'd15, 16'hFFFF);
    sel_o2 = 4'd15; sel_o1 = 4'd3;
    #1;
    n_vec++;
    if (o2 !== 16'hFFFF) begin
      n_miss++;
      $display("FAIL post_reset_r15: o2=%h required=ffff", o2);
    end
    n_vec++;
    if (o1 !== 16'h0000) begin
      n_miss++;
      $display("FAIL post_reset_r3: o1=%h required=0000", o1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
